// File: rtl/aes_keyexp_stream_if.sv
// Key-load, shared S-box and round-key stream signals of aes_keyexp_stream.
// master = surrounding system, slave = key-schedule engine.
interface aes_keyexp_stream_if;
    logic [7:0] key_in;
    logic       key_valid;
    logic       sbox_req;
    logic [7:0] sbox_addr;
    logic [7:0] sbox_data;
    logic       round_req;
    logic [7:0] rk_out;
    logic       rk_valid;
    logic       rk_ready;
    logic [3:0] rk_round;
    logic       rk_last;
    logic       busy;
    logic       done;

    modport master (
        output key_in, key_valid, sbox_data, round_req, rk_ready,
        input  sbox_req, sbox_addr, rk_out, rk_valid, rk_round, rk_last, busy, done
    );

    modport slave (
        input  key_in, key_valid, sbox_data, round_req, rk_ready,
        output sbox_req, sbox_addr, rk_out, rk_valid, rk_round, rk_last, busy, done
    );
endinterface

// File: rtl/aes_keyexp_stream.sv
// Byte-serial AES-128 key schedule: round keys 1..NUM_ROUNDS streamed with valid/ready.
// Optional macro AES_KEYEXP_STORE_ALL_EN adds a readable store of every round key.
module aes_keyexp_stream #(
    parameter int unsigned NUM_ROUNDS = 10,
    parameter int unsigned SBOX_LAT   = 1,
    parameter logic [7:0]  RCON_INIT  = 8'h01
) (
    input  logic               clk,
    input  logic               rst_n,
`ifdef AES_KEYEXP_STORE_ALL_EN
    input  logic [3:0]         rd_round,
    input  logic [3:0]         rd_idx,
    output logic [7:0]         rd_data,
`endif
    aes_keyexp_stream_if.slave bus
);
    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);
    localparam logic [3:0] LAT4       = 4'(SBOX_LAT);
    localparam logic [2:0] SUB_LAST   = 3'(SBOX_LAT + 3);

    typedef enum logic [2:0] {IDLE, LOAD, SUB, EXP, OUT, WAIT, FINISH} state_t;

    state_t     state_reg;
    logic [7:0] key_mem [0:15];
    logic [7:0] sub_reg [0:3];
    logic [3:0] cnt_reg;
    logic [2:0] sub_cnt_reg;
    logic [3:0] round_reg;
    logic [7:0] rcon_reg;
    logic       sbox_req_reg;
    logic [7:0] sbox_addr_reg;
    logic [7:0] rk_out_reg;
    logic       rk_valid_reg;
    logic [3:0] rk_round_reg;
    logic       rk_last_reg;
    logic       busy_reg;
    logic       done_reg;

    logic [3:0] cnt_inc;
    logic [2:0] sub_cnt_inc;
    logic [3:0] cap_off;
    logic [7:0] mix_byte;
    logic [7:0] new_byte;
    logic [7:0] rcon_next;
    logic       key_we;
    logic [7:0] key_wdata;

    assign cnt_inc     = cnt_reg + 4'd1;
    assign sub_cnt_inc = sub_cnt_reg + 3'd1;
    // Offset of the current SUB cycle from the first returned S-box byte; 0..3 means capture.
    assign cap_off     = {1'b0, sub_cnt_reg} - LAT4;
    assign rcon_next   = {rcon_reg[6:0], 1'b0} ^ (rcon_reg[7] ? 8'h1b : 8'h00);

    always_comb begin
        mix_byte = key_mem[cnt_reg - 4'd4];
        if (cnt_reg < 4'd4) begin
            mix_byte = sub_reg[cnt_reg[1:0]] ^ ((cnt_reg == 4'd0) ? rcon_reg : 8'h00);
        end
    end

    assign new_byte  = key_mem[cnt_reg] ^ mix_byte;
    assign key_we    = rst_n && ((((state_reg == IDLE) || (state_reg == LOAD)) && bus.key_valid)
                                 || (state_reg == EXP));
    assign key_wdata = (state_reg == EXP) ? new_byte : bus.key_in;

    // Working key is overwritten in place; bytes k-4 are already the new ones during EXP.
    always_ff @(posedge clk) begin
        if (key_we) begin
            key_mem[cnt_reg] <= key_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            cnt_reg       <= 4'd0;
            sub_cnt_reg   <= 3'd0;
            round_reg     <= 4'd0;
            rcon_reg      <= RCON_INIT;
            sbox_req_reg  <= 1'b0;
            sbox_addr_reg <= 8'h00;
            rk_out_reg    <= 8'h00;
            rk_valid_reg  <= 1'b0;
            rk_round_reg  <= 4'd0;
            rk_last_reg   <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                sub_reg[i] <= 8'h00;
            end
        end else begin
            done_reg     <= 1'b0;
            sbox_req_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.key_valid) begin
                        state_reg <= LOAD;
                        cnt_reg   <= 4'd1;
                        busy_reg  <= 1'b1;
                    end
                end
                LOAD: begin
                    if (bus.key_valid) begin
                        cnt_reg <= cnt_inc;
                        if (cnt_reg == 4'd15) begin
                            state_reg     <= SUB;
                            cnt_reg       <= 4'd0;
                            sub_cnt_reg   <= 3'd0;
                            sbox_req_reg  <= 1'b1;
                            sbox_addr_reg <= key_mem[13];
                        end
                    end
                end
                SUB: begin
                    if (cap_off[3:2] == 2'b00) begin
                        sub_reg[cap_off[1:0]] <= bus.sbox_data;
                    end
                    sub_cnt_reg <= sub_cnt_inc;
                    // RotWord order: requests go out for bytes 13, 14, 15, 12.
                    if (!sub_cnt_inc[2]) begin
                        sbox_req_reg  <= 1'b1;
                        sbox_addr_reg <= key_mem[{2'b11, sub_cnt_inc[1:0] + 2'b01}];
                    end
                    if (sub_cnt_reg == SUB_LAST) begin
                        state_reg <= EXP;
                        cnt_reg   <= 4'd0;
                    end
                end
                EXP: begin
                    cnt_reg <= cnt_inc;
                    if (cnt_reg == 4'd15) begin
                        state_reg    <= OUT;
                        rk_valid_reg <= 1'b1;
                        rk_out_reg   <= key_mem[0];
                        rk_last_reg  <= 1'b0;
                        rk_round_reg <= round_reg + 4'd1;
                    end
                end
                OUT: begin
                    if (bus.rk_ready) begin
                        if (cnt_reg == 4'd15) begin
                            rk_valid_reg <= 1'b0;
                            rk_last_reg  <= 1'b0;
                            rk_out_reg   <= 8'h00;
                            rk_round_reg <= 4'd0;
                            rcon_reg     <= rcon_next;
                            cnt_reg      <= 4'd0;
                            if (round_reg + 4'd1 >= LAST_ROUND) begin
                                round_reg <= LAST_ROUND;
                                state_reg <= FINISH;
                                done_reg  <= 1'b1;
                            end else begin
                                round_reg <= round_reg + 4'd1;
                                if (bus.round_req) begin
                                    state_reg     <= SUB;
                                    sub_cnt_reg   <= 3'd0;
                                    sbox_req_reg  <= 1'b1;
                                    sbox_addr_reg <= key_mem[13];
                                end else begin
                                    state_reg <= WAIT;
                                end
                            end
                        end else begin
                            cnt_reg     <= cnt_inc;
                            rk_out_reg  <= key_mem[cnt_inc];
                            rk_last_reg <= (cnt_inc == 4'd15);
                        end
                    end
                end
                WAIT: begin
                    if (bus.round_req) begin
                        state_reg     <= SUB;
                        cnt_reg       <= 4'd0;
                        sub_cnt_reg   <= 3'd0;
                        sbox_req_reg  <= 1'b1;
                        sbox_addr_reg <= key_mem[13];
                    end
                end
                FINISH: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                    rcon_reg  <= RCON_INIT;
                    round_reg <= 4'd0;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.sbox_req  = sbox_req_reg;
    assign bus.sbox_addr = sbox_addr_reg;
    assign bus.rk_out    = rk_out_reg;
    assign bus.rk_valid  = rk_valid_reg;
    assign bus.rk_round  = rk_round_reg;
    assign bus.rk_last   = rk_last_reg;
    assign bus.busy      = busy_reg;
    assign bus.done      = done_reg;

`ifdef AES_KEYEXP_STORE_ALL_EN
    localparam int unsigned STORE_DEPTH = (NUM_ROUNDS + 1) * 16;

    logic [7:0] store_mem [0:STORE_DEPTH-1];
    logic [7:0] store_waddr;
    logic [7:0] rd_data_reg;

    // Round 0 is the loaded key; round r lands at r*16 while it is expanded.
    assign store_waddr = (state_reg == EXP) ? {round_reg + 4'd1, cnt_reg} : {4'd0, cnt_reg};

    always_ff @(posedge clk) begin
        if (key_we) begin
            store_mem[store_waddr] <= key_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data_reg <= 8'h00;
        end else if (rd_round > LAST_ROUND) begin
            rd_data_reg <= 8'h00;
        end else begin
            rd_data_reg <= store_mem[{rd_round, rd_idx}];
        end
    end

    assign rd_data = rd_data_reg;
`endif
endmodule

// File: tb/tb_aes_keyexp_stream.sv
// Self-checking bench for aes_keyexp_stream: FIPS-197 key schedules, stalls, reset abort.
module tb_aes_keyexp_stream #(
    parameter int TB_LAT = 1
);
    typedef struct packed {
        logic [7:0] b;
        logic [3:0] rnd;
        logic       last;
    } exp_t;

    logic clk;
    logic rst_n;
    aes_keyexp_stream_if bus_if ();
`ifdef AES_KEYEXP_STORE_ALL_EN
    logic [3:0] rd_round;
    logic [3:0] rd_idx;
    logic [7:0] rd_data;
`endif

    int   total = 0;
    int   bad   = 0;
    int   done_cnt = 0;
    int   sreq_cnt = 0;
    exp_t exp_q[$];

    aes_keyexp_stream #(
        .NUM_ROUNDS(10),
        .SBOX_LAT  (TB_LAT),
        .RCON_INIT (8'h01)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
`ifdef AES_KEYEXP_STORE_ALL_EN
        .rd_round(rd_round),
        .rd_idx  (rd_idx),
        .rd_data (rd_data),
`endif
        .bus     (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box from first principles: GF(2^8) inverse (x^254) then the affine map.
    function automatic logic [7:0] sbox_f(input logic [7:0] x);
        logic [7:0] inv;
        inv = 8'h00;
        if (x != 8'h00) begin
            inv = 8'h01;
            for (int i = 0; i < 254; i++) inv = gmul(inv, x);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                   ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] r);
        return {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] next_rk(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, t;
        {w0, w1, w2, w3} = k;
        t  = {sbox_f(w3[23:16]), sbox_f(w3[15:8]), sbox_f(w3[7:0]), sbox_f(w3[31:24])}
             ^ {rc, 24'h000000};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // External S-box with TB_LAT cycles of latency; junk on the bus when no result is due.
    localparam int PIPE_IDX = (TB_LAT == 0) ? 0 : TB_LAT - 1;
    logic [7:0] addr_pipe [0:3];
    logic       req_pipe  [0:3];
    logic [7:0] noise;

    always @(posedge clk) begin
        addr_pipe[0] <= bus_if.sbox_addr;
        req_pipe[0]  <= bus_if.sbox_req;
        for (int i = 1; i < 4; i++) begin
            addr_pipe[i] <= addr_pipe[i-1];
            req_pipe[i]  <= req_pipe[i-1];
        end
        noise <= 8'($urandom);
    end

    always_comb begin
        if (TB_LAT == 0) begin
            bus_if.sbox_data = (bus_if.sbox_req === 1'b1) ? sbox_f(bus_if.sbox_addr) : noise;
        end else begin
            bus_if.sbox_data = (req_pipe[PIPE_IDX] === 1'b1) ? sbox_f(addr_pipe[PIPE_IDX]) : noise;
        end
    end

    always @(negedge clk) begin
        if (bus_if.done === 1'b1) done_cnt <= done_cnt + 1;
        if (bus_if.sbox_req === 1'b1) sreq_cnt <= sreq_cnt + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_round(input logic [127:0] k, input int rnd);
        exp_t e;
        exp_q.delete();
        for (int i = 0; i < 16; i++) begin
            e.b    = k[127-8*i -: 8];
            e.rnd  = 4'(rnd);
            e.last = (i == 15);
            exp_q.push_back(e);
        end
    endtask

    task automatic load_key(input logic [127:0] k);
        for (int i = 0; i < 16; i++) begin
            bus_if.key_in    = k[127-8*i -: 8];
            bus_if.key_valid = 1'b1;
            @(negedge clk);
        end
        bus_if.key_valid = 1'b0;
        bus_if.key_in    = 8'h00;
    endtask

    task automatic pulse_req();
        bus_if.round_req = 1'b1;
        @(negedge clk);
        bus_if.round_req = 1'b0;
    endtask

    // Called one negedge after the triggering byte/pulse (cycle 1); waits for rk_valid and drains 16 bytes.
    task automatic stream_round(input int rnd, input bit rand_ready, input bit req_last,
                                output logic [127:0] got);
        int         cyc;
        int         n;
        exp_t       e;
        logic       stalled;
        logic [7:0] held;
        cyc     = 1;
        n       = 0;
        stalled = 1'b0;
        held    = 8'h00;
        got     = '0;
        while (bus_if.rk_valid !== 1'b1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk($sformatf("r%0d_valid_latency", rnd), 128'(cyc), 128'(21 + TB_LAT));
        while (n < 16 && cyc < 2000) begin
            if (stalled) chk($sformatf("r%0d_stall_hold", rnd), 128'(bus_if.rk_out), 128'(held));
            bus_if.rk_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (bus_if.rk_valid === 1'b1 && bus_if.rk_ready) begin
                e = exp_q.pop_front();
                chk($sformatf("r%0d_byte%0d", rnd, n), 128'(bus_if.rk_out), 128'(e.b));
                chk($sformatf("r%0d_round%0d", rnd, n), 128'(bus_if.rk_round), 128'(e.rnd));
                chk($sformatf("r%0d_last%0d", rnd, n), 128'(bus_if.rk_last), 128'(e.last));
                $display("round %0d byte %0d rk_out=%02h", rnd, n, bus_if.rk_out);
                got     = {got[119:0], bus_if.rk_out};
                n++;
                stalled = 1'b0;
                if (n == 16 && req_last) bus_if.round_req = 1'b1;
            end else begin
                stalled = (bus_if.rk_valid === 1'b1);
                held    = bus_if.rk_out;
            end
            @(negedge clk);
            cyc++;
        end
        chk($sformatf("r%0d_bytes_streamed", rnd), 128'(n), 128'd16);
        bus_if.rk_ready  = 1'b1;
        bus_if.round_req = 1'b0;
    endtask

    initial begin
        logic [127:0] key;
        logic [127:0] rk;
        logic [127:0] got;
        logic [7:0]   rcon;

        rst_n            = 1'b0;
        bus_if.key_in    = 8'h00;
        bus_if.key_valid = 1'b0;
        bus_if.round_req = 1'b0;
        bus_if.rk_ready  = 1'b1;
`ifdef AES_KEYEXP_STORE_ALL_EN
        rd_round = 4'd0;
        rd_idx   = 4'd0;
`endif
        repeat (3) @(negedge clk);
        chk("reset_outputs", 128'({bus_if.sbox_req, bus_if.sbox_addr, bus_if.rk_out, bus_if.rk_valid,
                                    bus_if.rk_round, bus_if.rk_last, bus_if.busy, bus_if.done}), 128'd0);
`ifdef AES_KEYEXP_STORE_ALL_EN
        chk("reset_rd_data", 128'(rd_data), 128'd0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        // Full FIPS-197 schedule; round 5 is started by round_req held at byte 15 of round 4.
        key  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        rk   = key;
        rcon = 8'h01;
        load_key(key);
        for (int r = 1; r <= 10; r++) begin
            rk = next_rk(rk, rcon);
            push_round(rk, r);
            if (r > 1 && r != 5) begin
                repeat (2) @(negedge clk);
                chk($sformatf("r%0d_wait_state", r),
                    128'({bus_if.busy, bus_if.rk_valid, bus_if.sbox_req}), 128'(3'b100));
                pulse_req();
            end
            stream_round(r, 1'b0, (r == 4), got);
            if (r == 1) chk("fips_round1", got, 128'ha0fafe1788542cb123a339392a6c7605);
            rcon = xt(rcon);
        end
        chk("fips_round10", got, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        chk("done_pulse", 128'({bus_if.done, bus_if.busy}), 128'(2'b11));
        @(negedge clk);
        chk("done_cleared_busy_low", 128'({bus_if.done, bus_if.busy}), 128'(2'b00));
        chk("done_count", 128'(done_cnt), 128'd1);
        chk("sbox_req_count", 128'(sreq_cnt), 128'd40);

`ifdef AES_KEYEXP_STORE_ALL_EN
        rd_round = 4'd10; rd_idx = 4'd0;
        @(negedge clk);
        chk("store_r10_b0", 128'(rd_data), 128'hd0);
        rd_round = 4'd0; rd_idx = 4'd15;
        @(negedge clk);
        chk("store_r0_b15", 128'(rd_data), 128'h3c);
        rd_round = 4'd11; rd_idx = 4'd0;
        @(negedge clk);
        chk("store_out_of_range", 128'(rd_data), 128'h00);
`endif

        // Same key with random backpressure; rcon must have restarted at 01.
        rk   = key;
        rcon = 8'h01;
        load_key(key);
        rk = next_rk(rk, rcon);
        push_round(rk, 1);
        stream_round(1, 1'b1, 1'b0, got);
        chk("stall_round1", got, 128'ha0fafe1788542cb123a339392a6c7605);
        rcon = xt(rcon);
        rk   = next_rk(rk, rcon);
        push_round(rk, 2);
        bus_if.key_in    = 8'hff;
        bus_if.key_valid = 1'b1;
        repeat (2) @(negedge clk);
        bus_if.key_valid = 1'b0;
        pulse_req();
        stream_round(2, 1'b0, 1'b0, got);

        // Abort during EXP of round 3, then restart on a new key.
        pulse_req();
        repeat (9 + TB_LAT) @(negedge clk);
        chk("r3_in_exp", 128'({bus_if.busy, bus_if.rk_valid, bus_if.sbox_req}), 128'(3'b100));
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_outputs", 128'({bus_if.sbox_req, bus_if.sbox_addr, bus_if.rk_out, bus_if.rk_valid,
                                    bus_if.rk_round, bus_if.rk_last, bus_if.busy, bus_if.done}), 128'd0);
        rst_n = 1'b1;
        exp_q.delete();
        @(negedge clk);

        key  = 128'h000102030405060708090a0b0c0d0e0f;
        rcon = 8'h01;
        load_key(key);
        rk = next_rk(key, rcon);
        push_round(rk, 1);
        stream_round(1, 1'b0, 1'b0, got);
        chk("reload_round1", got, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
